led_pattern_gen: RTL and testbench
==================================

Name: led_pattern_gen

Overview:
- Multi-channel LED driver for board status indication.
- Each channel has its own speed select and mode: off, on, blink, or breathe (triangle-ramped PWM).
- A shared prescaler and a shared PWM counter serve all channels; all outputs are registered.
- Sits between the control/status logic and the board LED pins.

Parameters:
- NUM_CH, 4: number of independent LED channels.
- SPEED_W, 2: width of each channel's speed select.
- BASE_DIV, 16: clk cycles per prescaler tick; must be >= 2.
- PWM_W, 4: width of the PWM counter and of each breathe duty register.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- speed  in  NUM_CH*SPEED_W  per-channel speed; channel i uses bits [i*SPEED_W +: SPEED_W]; larger value = faster.
- mode  in  NUM_CH*2  per-channel mode; 00 off, 01 on, 10 blink, 11 breathe.
- led  out  NUM_CH  LED drive; bit i is channel i; registered.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset is synchronous, active-low, on rst_n.
  - While rst_n=0 at a clk edge, every register clears: prescaler, pwm_cnt, ch_cnt, phase, duty, dir, speed/mode shadow registers, and led (led=0).
- Prescaler:
  - pre_cnt counts 0..BASE_DIV-1 and wraps.
  - tick is high for the one cycle in which pre_cnt==BASE_DIV-1.
  - First tick occurs in the BASE_DIV-th cycle after reset release.
- Channel period:
  - SMAX = 2^SPEED_W-1; LIM(s) = 2^(SMAX-s) ticks.
  - With SPEED_W=2: s=0 gives LIM 8, s=3 gives LIM 1.
  - ch_cnt has SMAX bits and increments on tick.
  - On a tick with ch_cnt==LIM-1: ch_cnt goes to 0 and a one-cycle event fires.
- Blink:
  - phase toggles on each event.
  - led <= phase, i.e. led follows phase one cycle later.
  - Full period = 2*LIM*BASE_DIV clk.
- Breathe:
  - pwm_cnt is a free-running PWM_W-bit counter, incrementing every clk and wrapping.
  - On each event, with dir=up: if duty==2^PWM_W-1, set dir=down and duty=max-1; otherwise duty+1.
  - On each event, with dir=down: if duty==0, set dir=up and duty=1; otherwise duty-1.
  - led <= (pwm_cnt < duty). duty=0 is always dark.
- Off/on: led <= 0 / led <= 1. ch_cnt keeps running.
- Change handling:
  - speed and mode are sampled every cycle into shadow registers.
  - If a channel's speed or mode differs from its shadow, that channel's ch_cnt, phase, duty and dir clear that cycle (dir clears to up). The event is suppressed in that cycle.
  - Blink therefore restarts dark, and breathe restarts at duty 0.
  - The prescaler and other channels are unaffected.
- Simultaneous events: a change and a tick in the same cycle resolve as the change (clear wins).
- Mid-run reset: rst_n low on any edge overrides everything, and led=0 on the next cycle.
- Wrap-around: all counters wrap silently; there are no error outputs.

Optional Feature:
- Macro LED_ACTIVE_LOW_EN.
- Defined: the led output is inverted after the registered logic; reset value is all-ones; off mode drives 1 and on mode drives 0.
- Undefined: active-high as described above.
- Internal state is identical in both builds.

Decomposition:
- Package led_pkg holds:
  - mode encodings MODE_OFF, MODE_ON, MODE_BLINK, MODE_BREATHE as 2-bit localparams;
  - function lim_of(speed, SPEED_W).
- Sub-module led_channel: one per channel, generated NUM_CH times.
  - Inputs: tick, pwm_cnt, speed slice, mode slice.
  - Contains the shadow registers, ch_cnt, phase, duty, dir and the led register.
- The top holds the prescaler, pwm_cnt and the generate loop.

Test Plan (BASE_DIV=4, SPEED_W=2, PWM_W=4, NUM_CH=4):
- Reset check: hold rst_n=0 for 3 cycles with mode=all blink -> led=0000 throughout; led stays 0 for the first 4 cycles after release.
- Blink periods: ch0 speed=3, ch1 speed=0, both blink -> led[0] period 8 clk, 50% duty; led[1] period 64 clk; led[0] first rises 5 clk after reset release.
- Off/on: mode=01 on ch2, 00 on ch3 -> led[2]=1 constantly from 1 cycle after reset release; led[3]=0.
- Breathe: ch0 breathe, speed=3 -> duty steps 0,1..15,14..0 once per 4 clk. At duty 8, led[0] is high 8 of every 16 clk. duty reaches 15 after 60 clk, then descends.
- Speed change mid-period: switch ch0 speed 0->3 while led[0]=1 -> led[0]=0 within 2 cycles, then period 8 clk. Other channels' edges are unshifted.
- Active-low build (LED_ACTIVE_LOW_EN defined): rerun the reset and blink checks -> led=1111 during reset, waveforms bitwise inverted.

Source files
------------

// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern generator: mode encodings, breathe
// ramp direction and the per-speed channel period helper.
package led_pkg;

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_ON      = 2'b01;
  localparam logic [1:0] MODE_BLINK   = 2'b10;
  localparam logic [1:0] MODE_BREATHE = 2'b11;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Channel period in prescaler ticks: 2^(SMAX - speed), so a larger speed is faster.
  function automatic int lim_of(input int speed, input int speed_w);
    int smax;
    smax = (1 << speed_w) - 1;
    return 1 << (smax - speed);
  endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: input shadowing, period counter, blink phase, breathe
// duty ramp and the registered LED drive.
module led_channel
  import led_pkg::*;
#(
  parameter int SPEED_W = 2,
  parameter int PWM_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic [PWM_W-1:0]   pwm_cnt,
  input  logic [SPEED_W-1:0] speed,
  input  logic [1:0]         mode,
  output logic               led
);

  localparam int CNT_W = (1 << SPEED_W) - 1;
  localparam logic [PWM_W-1:0] DUTY_MAX = '1;

  logic [SPEED_W-1:0] speed_q;
  logic [1:0]         mode_q;
  logic [CNT_W-1:0]   ch_cnt;
  logic [CNT_W-1:0]   lim_m1;
  logic               phase;
  logic [PWM_W-1:0]   duty;
  dir_e               dir;
  logic               changed;
  logic               wrap;
  logic               evt;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    lim_m1  = CNT_W'(lim_of(int'(speed), SPEED_W) - 1);
    changed = (speed != speed_q) || (mode != mode_q);
    wrap    = tick && (ch_cnt == lim_m1);
    evt     = wrap && !changed;
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; the shadows are reset too so a post-reset setting counts as a change.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      speed_q <= '0;
      mode_q  <= MODE_OFF;
      ch_cnt  <= '0;
      phase   <= 1'b0;
      duty    <= '0;
      dir     <= DIR_UP;
      led     <= 1'b0;
    end else begin
      speed_q <= speed;
      mode_q  <= mode;

      // A speed/mode change restarts the channel and swallows any coincident event.
      if (changed) begin
        ch_cnt <= '0;
        phase  <= 1'b0;
        duty   <= '0;
        dir    <= DIR_UP;
      end else begin
        if (tick) begin
          ch_cnt <= wrap ? '0 : ch_cnt + 1'b1;
        end
        if (evt) begin
          phase <= ~phase;
          if (dir == DIR_UP) begin
            if (duty == DUTY_MAX) begin
              dir  <= DIR_DOWN;
              duty <= DUTY_MAX - 1'b1;
            end else begin
              duty <= duty + 1'b1;
            end
          end else begin
            if (duty == '0) begin
              dir  <= DIR_UP;
              duty <= PWM_W'(1);
            end else begin
              duty <= duty - 1'b1;
            end
          end
        end
      end

      case (mode)
        MODE_OFF:     led <= 1'b0;
        MODE_ON:      led <= 1'b1;
        MODE_BLINK:   led <= phase;
        MODE_BREATHE: led <= (pwm_cnt < duty);
      endcase
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: shared prescaler and PWM counter feeding NUM_CH
// channels. Define LED_ACTIVE_LOW_EN to invert the LED pins (active-low boards).
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int SPEED_W  = 2,
  parameter int BASE_DIV = 16,
  parameter int PWM_W    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH*SPEED_W-1:0] speed,
  input  logic [NUM_CH*2-1:0]       mode,
  output logic [NUM_CH-1:0]         led
);

  // BASE_DIV must be at least 2 so the prescaler has a distinct wrap state.
  localparam int PRE_W = $clog2(BASE_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BASE_DIV - 1);

  logic [PRE_W-1:0]  pre_cnt;
  logic [PWM_W-1:0]  pwm_cnt;
  logic              tick;
  logic [NUM_CH-1:0] led_raw;

  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    led_channel #(
      .SPEED_W (SPEED_W),
      .PWM_W   (PWM_W)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick    (tick),
      .pwm_cnt (pwm_cnt),
      .speed   (speed[i*SPEED_W +: SPEED_W]),
      .mode    (mode[2*i +: 2]),
      .led     (led_raw[i])
    );
  end

`ifdef LED_ACTIVE_LOW_EN
  assign led = ~led_raw;
`else
  assign led = led_raw;
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with BASE_DIV=4: table of post-reset
// snapshots plus hand sequences for reset, mid-run reset and speed change.
module tb_led_pattern_gen;

`ifdef LED_ACTIVE_LOW_EN
  localparam logic [3:0] INV = 4'hF;
`else
  localparam logic [3:0] INV = 4'h0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] speed;
  logic [7:0] mode;
  logic [3:0] led;

  int tests;
  int fails;
  int cur_k;

  typedef struct {
    logic [7:0] speed;
    logic [7:0] mode;
    int         k;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];

  led_pattern_gen #(
    .NUM_CH   (4),
    .SPEED_W  (2),
    .BASE_DIV (4),
    .PWM_W    (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .speed (speed),
    .mode  (mode),
    .led   (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected values are given active-high and flipped here for the active-low build.
  task automatic check(input string name, input logic [3:0] exp_hi);
    logic [3:0] exp;
    exp = exp_hi ^ INV;
    tests++;
    if (led !== exp) begin
      fails++;
      $display("FAIL %s: led=%b expected %b", name, led, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [7:0] s, input logic [7:0] m);
    rst_n = 1'b0;
    speed = s;
    mode  = m;
    repeat (3) step();
    rst_n = 1'b1;
    cur_k = 0;
  endtask

  task automatic add(input logic [7:0] s, input logic [7:0] m, input int k,
                     input logic [3:0] e);
    vec_t v;
    v.speed = s;
    v.mode  = m;
    v.k     = k;
    v.exp   = e;
    vecs.push_back(v);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cur_k = -1;
    rst_n = 1'b0;
    speed = 8'h00;
    mode  = 8'h00;

    // Blink ch0 fast (period 8), blink ch1 slow (period 64), ch2 on, ch3 off.
    add(8'h03, 8'h1A,   1, 4'b0100);
    add(8'h03, 8'h1A,   4, 4'b0100);
    add(8'h03, 8'h1A,   5, 4'b0101);
    add(8'h03, 8'h1A,   8, 4'b0101);
    add(8'h03, 8'h1A,   9, 4'b0100);
    add(8'h03, 8'h1A,  13, 4'b0101);
    add(8'h03, 8'h1A,  32, 4'b0101);
    add(8'h03, 8'h1A,  33, 4'b0110);
    add(8'h03, 8'h1A,  64, 4'b0111);
    add(8'h03, 8'h1A,  65, 4'b0100);
    add(8'h03, 8'h1A,  97, 4'b0110);
    // Breathe ch0 at speed 3: duty steps every 4 clk, peak 15 at 60 clk, floor at 120 clk.
    add(8'h03, 8'h03,   1, 4'b0000);
    add(8'h03, 8'h03,   5, 4'b0000);
    add(8'h03, 8'h03,  17, 4'b0001);
    add(8'h03, 8'h03,  20, 4'b0001);
    add(8'h03, 8'h03,  21, 4'b0001);
    add(8'h03, 8'h03,  22, 4'b0000);
    add(8'h03, 8'h03,  33, 4'b0001);
    add(8'h03, 8'h03,  41, 4'b0001);
    add(8'h03, 8'h03,  43, 4'b0000);
    add(8'h03, 8'h03,  61, 4'b0001);
    add(8'h03, 8'h03,  64, 4'b0000);
    add(8'h03, 8'h03,  66, 4'b0001);
    add(8'h03, 8'h03,  76, 4'b0001);
    add(8'h03, 8'h03,  77, 4'b0000);
    add(8'h03, 8'h03,  79, 4'b0000);
    add(8'h03, 8'h03, 113, 4'b0001);
    add(8'h03, 8'h03, 115, 4'b0000);
    add(8'h03, 8'h03, 121, 4'b0000);
    add(8'h03, 8'h03, 125, 4'b0000);
    add(8'h03, 8'h03, 129, 4'b0001);

    // Reset hold with all channels blinking fast, then the first four cycles stay dark.
    rst_n = 1'b0;
    speed = 8'hFF;
    mode  = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("reset_hold_%0d", i), 4'b0000);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("post_reset_k%0d", k), 4'b0000);
    end
    step();
    check("first_rise_k5", 4'b1111);

    for (int i = 0; i < vecs.size(); i++) begin
      if (cur_k < 0 || vecs[i].speed != speed || vecs[i].mode != mode || vecs[i].k <= cur_k)
        do_reset(vecs[i].speed, vecs[i].mode);
      while (cur_k < vecs[i].k) begin
        step();
        cur_k++;
      end
      check($sformatf("vec%0d_k%0d", i, vecs[i].k), vecs[i].exp);
    end

    // Mid-run reset: all on, then rst_n low clears led on the next edge.
    do_reset(8'h00, 8'h55);
    repeat (3) step();
    check("all_on", 4'b1111);
    rst_n = 1'b0;
    step();
    check("midrun_reset", 4'b0000);
    rst_n = 1'b1;
    step();
    check("after_midrun_reset", 4'b1111);

    // Speed change on ch0 (0 -> 3) while lit; ch1 fast blink must keep its edges.
    do_reset(8'h0C, 8'h0A);
    repeat (34) step();
    check("spd_before_k34", 4'b0001);
    speed = 8'h0F;
    step();
    check("spd_chg_k35", 4'b0001);
    step();
    check("spd_chg_k36", 4'b0000);
    step();
    check("spd_chg_k37", 4'b0011);
    repeat (3) step();
    check("spd_chg_k40", 4'b0011);
    step();
    check("spd_chg_k41", 4'b0000);
    repeat (4) step();
    check("spd_chg_k45", 4'b0011);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
